// File: rtl/dm_bus_responder.sv
// dm_bus_responder: data-memory responder with byte-merge RAM, countdown timer and write trace
module dm_bus_responder #(
   parameter int unsigned DM_WORDS   = 3072,
   parameter logic [31:0] TIMER_BASE = 32'h0000_7F00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] m_data_addr,
   input  logic [31:0] m_data_wdata,
   input  logic [3:0]  m_data_byteen,
   input  logic [31:0] m_inst_addr,
   output logic [31:0] m_data_rdata,
   output logic        irq,
   output logic        dm_trace_we,
   output logic [31:0] dm_trace_pc,
   output logic [31:0] dm_trace_addr,
   output logic [31:0] dm_trace_wdata
);
   localparam int AW = $clog2(DM_WORDS);
   typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
   state_t state;
   logic [31:0] mem [DM_WORDS];
   logic [DM_WORDS-1:0] vld;
   logic [3:0] ctrl;
   logic [31:0] preset, count, old_word, merged;
   logic [29:0] word;
   logic [AW-1:0] idx;
   logic ram_hit, t_ctrl, t_pre, t_cnt, ram_we, tim_we;
   assign word = m_data_addr[31:2];
   assign idx = m_data_addr[AW+1:2];
   assign ram_hit = m_data_addr < 32'(4 * DM_WORDS);
   assign t_ctrl = word == TIMER_BASE[31:2];
   assign t_pre = word == TIMER_BASE[31:2] + 30'd1;
   assign t_cnt = word == TIMER_BASE[31:2] + 30'd2;
   // a cleared valid bit reads as zero, so reset clears the whole RAM in one edge
   assign old_word = ram_hit && vld[idx] ? mem[idx] : '0;
   always_comb begin
      merged = old_word;
      for (int i = 0; i < 4; i++) merged[8*i +: 8] = m_data_byteen[i] ? m_data_wdata[8*i +: 8] : old_word[8*i +: 8];
   end
   assign m_data_rdata = ram_hit ? old_word : t_ctrl ? {28'b0, ctrl} : t_pre ? preset : t_cnt ? count : '0;
   assign ram_we = ram_hit && |m_data_byteen;
   assign tim_we = !ram_hit && &m_data_byteen && (t_ctrl || t_pre);
   assign irq = state == INT && ctrl[3];
   assign dm_trace_we = ram_we || tim_we;
   assign dm_trace_pc = m_inst_addr;
   assign dm_trace_addr = {word, 2'b00};
   assign dm_trace_wdata = ram_hit ? merged : t_ctrl ? {28'b0, m_data_wdata[3:0]} : m_data_wdata;
   always_ff @(posedge clk) if (ram_we && !reset) mem[idx] <= merged;
   always_ff @(posedge clk) begin
      if (reset) begin
         vld <= '0;
         ctrl <= '0;
         preset <= '0;
         count <= '0;
         state <= IDLE;
      end else begin
         if (ram_we) vld[idx] <= 1'b1;
         case (state)
            IDLE: if (ctrl[0]) state <= LOAD;
            LOAD: begin
               count <= preset;
               state <= CNT;
            end
            CNT: if (!ctrl[0]) state <= IDLE;
               else if (count > 32'd1) count <= count - 32'd1;
               else begin
                  count <= '0;
                  state <= INT;
               end
            default: begin
               state <= IDLE;
               if (ctrl[2:1] != 2'b01) ctrl[0] <= 1'b0;
            end
         endcase
         // CPU write follows the FSM so it overrides the one-shot EN clear
         if (tim_we && t_ctrl) ctrl <= m_data_wdata[3:0];
         if (tim_we && t_pre) preset <= m_data_wdata;
      end
   end
endmodule

// File: tb/tb_dm_bus_responder.sv
// tb_dm_bus_responder: randomized and directed checks of the data-memory responder against a behavioural model
module tb_dm_bus_responder;
   localparam logic [31:0] T_CTRL = 32'h7F00, T_PRE = 32'h7F04, T_CNT = 32'h7F08;
   localparam int WORDS = 3072;
   logic clk = 0, reset = 1;
   logic [31:0] addr = 0, wdata = 0, pc = 0;
   logic [3:0] be = 0;
   logic [31:0] rdata, tr_pc, tr_addr, tr_wdata;
   logic irq, tr_we;
   int checks = 0, passed = 0;
   logic [31:0] model [int];
   dm_bus_responder dut (
      .clk(clk), .reset(reset), .m_data_addr(addr), .m_data_wdata(wdata), .m_data_byteen(be),
      .m_inst_addr(pc), .m_data_rdata(rdata), .irq(irq), .dm_trace_we(tr_we),
      .dm_trace_pc(tr_pc), .dm_trace_addr(tr_addr), .dm_trace_wdata(tr_wdata)
   );
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      addr = a;
      wdata = d;
      be = b;
      #1;
   endtask
   task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
      drive(a, d, 4'hf);
      tick;
      be = 0;
   endtask
   function automatic logic [31:0] mget(input int w);
      return model.exists(w) ? model[w] : 32'h0;
   endfunction
   task automatic test_reset;
      drive(32'h10, 32'h0, 4'h0);
      tick;
      checks++; if (rdata !== 32'h0) $display("FAIL reset_rdata got %h want %h", rdata, 32'h0); else passed++;
      checks++; if (irq !== 1'b0) $display("FAIL reset_irq got %b want 0", irq); else passed++;
      checks++; if (tr_we !== 1'b0) $display("FAIL reset_trace_we got %b want 0", tr_we); else passed++;
      reset = 0;
      tick;
      foreach (model[i]) model.delete(i);
      for (int i = 0; i < 3; i++) begin
         addr = T_CTRL + 32'(4 * i);
         #1;
         checks++; if (rdata !== 32'h0) $display("FAIL reset_timer%0d got %h want %h", i, rdata, 32'h0); else passed++;
      end
   endtask
   task automatic test_ram_merge;
      pc = 32'h0000_0400;
      drive(32'h4, 32'h1234_5678, 4'hf);
      checks++; if (tr_we !== 1'b1 || tr_wdata !== 32'h1234_5678) $display("FAIL merge_trace1 got we=%b %h want we=1 %h", tr_we, tr_wdata, 32'h1234_5678); else passed++;
      tick;
      model[1] = 32'h1234_5678;
      drive(32'h5, 32'h0000_AB00, 4'b0010);
      checks++; if (tr_addr !== 32'h4) $display("FAIL merge_trace_addr got %h want %h", tr_addr, 32'h4); else passed++;
      checks++; if (tr_wdata !== 32'h1234_AB78) $display("FAIL merge_trace_wdata got %h want %h", tr_wdata, 32'h1234_AB78); else passed++;
      checks++; if (tr_pc !== 32'h0000_0400) $display("FAIL merge_trace_pc got %h want %h", tr_pc, 32'h0000_0400); else passed++;
      tick;
      model[1] = 32'h1234_AB78;
      drive(32'h4, 32'h0, 4'h0);
      checks++; if (rdata !== 32'h1234_AB78) $display("FAIL merge_read got %h want %h", rdata, 32'h1234_AB78); else passed++;
   endtask
   task automatic test_rdw;
      drive(32'h8, 32'hFFFF_FFFF, 4'hf);
      checks++; if (rdata !== 32'h0) $display("FAIL rdw_old got %h want %h", rdata, 32'h0); else passed++;
      tick;
      be = 0;
      #1;
      model[2] = 32'hFFFF_FFFF;
      checks++; if (rdata !== 32'hFFFF_FFFF) $display("FAIL rdw_new got %h want %h", rdata, 32'hFFFF_FFFF); else passed++;
   endtask
   task automatic test_random_ram;
      int sel, w;
      logic [31:0] a, d, old, nw;
      logic [3:0] b;
      logic wr;
      repeat (120) begin
         sel = $urandom_range(0, 9);
         w = sel == 0 ? WORDS + $urandom_range(0, 15) : sel == 1 ? WORDS - 1 - $urandom_range(0, 3) : $urandom_range(0, 63);
         a = (32'(w) << 2) | 32'($urandom_range(0, 3));
         d = $urandom;
         b = 4'($urandom_range(0, 15));
         pc = $urandom;
         old = w < WORDS ? mget(w) : 32'h0;
         nw = old;
         for (int i = 0; i < 4; i++) if (b[i]) nw[8*i +: 8] = d[8*i +: 8];
         wr = w < WORDS && b != 0;
         drive(a, d, b);
         checks++; if (rdata !== old) $display("FAIL rand_rdata addr=%h got %h want %h", a, rdata, old); else passed++;
         checks++; if (tr_we !== wr) $display("FAIL rand_trace_we addr=%h got %b want %b", a, tr_we, wr); else passed++;
         if (wr) begin
            checks++; if (tr_wdata !== nw || tr_addr !== 32'(w) << 2 || tr_pc !== pc) $display("FAIL rand_trace addr=%h got %h/%h/%h want %h/%h/%h", a, tr_addr, tr_wdata, tr_pc, 32'(w) << 2, nw, pc); else passed++;
            model[w] = nw;
         end
         tick;
      end
      be = 0;
   endtask
   task automatic test_oneshot(input logic [31:0] p);
      int kint;
      logic [31:0] exp;
      kint = p > 1 ? int'(p) + 2 : 3;
      cpu_write(T_PRE, p);
      cpu_write(T_CTRL, 32'h9);
      addr = T_CNT;
      for (int k = 1; k <= kint + 2; k++) begin
         tick;
         exp = (k < 2 || k >= kint) ? 32'h0 : p - 32'(k - 2);
         checks++; if (rdata !== exp) $display("FAIL oneshot_count p=%0d k=%0d got %h want %h", p, k, rdata, exp); else passed++;
         checks++; if (irq !== (k == kint)) $display("FAIL oneshot_irq p=%0d k=%0d got %b want %b", p, k, irq, k == kint); else passed++;
      end
      addr = T_CTRL;
      #1;
      checks++; if (rdata !== 32'h8) $display("FAIL oneshot_ctrl got %h want %h", rdata, 32'h8); else passed++;
   endtask
   task automatic test_autoreload;
      cpu_write(T_PRE, 32'h0);
      cpu_write(T_CTRL, 32'hB);
      addr = T_CNT;
      for (int k = 1; k <= 12; k++) begin
         tick;
         checks++; if (irq !== (k % 4 == 3)) $display("FAIL reload_irq k=%0d got %b want %b", k, irq, k % 4 == 3); else passed++;
         checks++; if (rdata !== 32'h0) $display("FAIL reload_count k=%0d got %h want %h", k, rdata, 32'h0); else passed++;
      end
      addr = T_CTRL;
      #1;
      checks++; if (rdata !== 32'hB) $display("FAIL reload_ctrl got %h want %h", rdata, 32'hB); else passed++;
      cpu_write(T_CTRL, 32'h0);
      repeat (4) tick;
      cpu_write(T_CTRL, 32'h3);
      addr = T_CNT;
      for (int k = 1; k <= 12; k++) begin
         tick;
         checks++; if (irq !== 1'b0) $display("FAIL masked_irq k=%0d got %b want 0", k, irq); else passed++;
      end
      cpu_write(T_CTRL, 32'h0);
      repeat (4) tick;
   endtask
   task automatic test_simultaneous;
      cpu_write(T_PRE, 32'h0);
      cpu_write(T_CTRL, 32'h9);
      repeat (3) tick;
      checks++; if (irq !== 1'b1) $display("FAIL simul_int_irq got %b want 1", irq); else passed++;
      cpu_write(T_CTRL, 32'h9);
      addr = T_CTRL;
      #1;
      checks++; if (rdata !== 32'h9) $display("FAIL simul_cpu_wins got %h want %h", rdata, 32'h9); else passed++;
      repeat (3) tick;
      checks++; if (irq !== 1'b1) $display("FAIL simul_second_irq got %b want 1", irq); else passed++;
      tick;
      checks++; if (rdata !== 32'h8) $display("FAIL simul_ctrl_after got %h want %h", rdata, 32'h8); else passed++;
      cpu_write(T_PRE, 32'h5);
      cpu_write(T_CTRL, 32'h9);
      repeat (3) tick;
      cpu_write(T_PRE, 32'h1);
      addr = T_CNT;
      #1;
      checks++; if (rdata !== 32'h3) $display("FAIL simul_preset_midcount got %h want %h", rdata, 32'h3); else passed++;
      repeat (3) tick;
      checks++; if (irq !== 1'b1 || rdata !== 32'h0) $display("FAIL simul_finish got irq=%b %h want irq=1 %h", irq, rdata, 32'h0); else passed++;
      tick;
      cpu_write(T_CTRL, 32'h9);
      addr = T_CNT;
      repeat (2) tick;
      checks++; if (rdata !== 32'h1) $display("FAIL simul_new_preset got %h want %h", rdata, 32'h1); else passed++;
      tick;
      checks++; if (irq !== 1'b1) $display("FAIL simul_preset1_irq got %b want 1", irq); else passed++;
      tick;
   endtask
   task automatic test_ignored;
      drive(T_CTRL, 32'hF, 4'b0001);
      checks++; if (tr_we !== 1'b0) $display("FAIL partial_trace got %b want 0", tr_we); else passed++;
      tick;
      be = 0;
      #1;
      checks++; if (rdata !== 32'h8) $display("FAIL partial_ctrl got %h want %h", rdata, 32'h8); else passed++;
      drive(T_CNT, 32'h55, 4'hf);
      checks++; if (tr_we !== 1'b0) $display("FAIL count_write_trace got %b want 0", tr_we); else passed++;
      tick;
      be = 0;
      #1;
      checks++; if (rdata !== 32'h0) $display("FAIL count_write got %h want %h", rdata, 32'h0); else passed++;
      drive(32'h3000, 32'hDEAD_BEEF, 4'hf);
      checks++; if (tr_we !== 1'b0 || rdata !== 32'h0) $display("FAIL unmapped got we=%b %h want we=0 %h", tr_we, rdata, 32'h0); else passed++;
      tick;
      be = 0;
      #1;
      checks++; if (rdata !== 32'h0) $display("FAIL unmapped_read got %h want %h", rdata, 32'h0); else passed++;
      drive(T_CTRL + 32'hC, 32'h1, 4'hf);
      checks++; if (tr_we !== 1'b0 || rdata !== 32'h0) $display("FAIL timer_gap got we=%b %h want we=0 %h", tr_we, rdata, 32'h0); else passed++;
      tick;
      drive(T_PRE, 32'hCAFE_0000, 4'hf);
      checks++; if (tr_we !== 1'b1 || tr_addr !== T_PRE || tr_wdata !== 32'hCAFE_0000) $display("FAIL preset_trace got %b/%h/%h want 1/%h/%h", tr_we, tr_addr, tr_wdata, T_PRE, 32'hCAFE_0000); else passed++;
      tick;
      drive(T_CTRL, 32'hFFFF_FFF8, 4'hf);
      checks++; if (tr_we !== 1'b1 || tr_wdata !== 32'h8) $display("FAIL ctrl_trace got %b/%h want 1/%h", tr_we, tr_wdata, 32'h8); else passed++;
      tick;
      be = 0;
      #1;
      checks++; if (rdata !== 32'h8) $display("FAIL ctrl_masked got %h want %h", rdata, 32'h8); else passed++;
   endtask
   task automatic test_reset_midcount;
      cpu_write(T_PRE, 32'h5);
      cpu_write(T_CTRL, 32'h9);
      addr = T_CNT;
      repeat (5) tick;
      checks++; if (rdata !== 32'h2) $display("FAIL midcount_pre got %h want %h", rdata, 32'h2); else passed++;
      reset = 1;
      drive(32'h20, 32'h1234_5678, 4'hf);
      tick;
      reset = 0;
      drive(T_CNT, 32'h0, 4'h0);
      foreach (model[i]) model.delete(i);
      checks++; if (rdata !== 32'h0 || irq !== 1'b0) $display("FAIL midcount_reset got %h irq=%b want %h irq=0", rdata, irq, 32'h0); else passed++;
      repeat (3) tick;
      checks++; if (rdata !== 32'h0 || irq !== 1'b0) $display("FAIL midcount_idle got %h irq=%b want %h irq=0", rdata, irq, 32'h0); else passed++;
      addr = 32'h20;
      #1;
      checks++; if (rdata !== 32'h0) $display("FAIL midcount_discard got %h want %h", rdata, 32'h0); else passed++;
      addr = T_CTRL;
      #1;
      checks++; if (rdata !== 32'h0) $display("FAIL midcount_ctrl got %h want %h", rdata, 32'h0); else passed++;
      addr = 32'h4;
      #1;
      checks++; if (rdata !== 32'h0) $display("FAIL midcount_ram_clear got %h want %h", rdata, 32'h0); else passed++;
   endtask
   initial begin
      test_reset;
      test_ram_merge;
      test_rdw;
      test_random_ram;
      test_oneshot(32'h3);
      test_oneshot(32'($urandom_range(0, 6)));
      test_autoreload;
      test_simultaneous;
      test_ignored;
      test_reset_midcount;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
